// File: rtl/sudoku_cell_serializer.sv
// sudoku_cell_serializer
//
// Streams a packed 9x9 Sudoku grid out one cell per valid/ready handshake.
// Cells go out in row-major order, each tagged with its row and column.
// While streaming, the block counts cells whose value is zero. When the last
// cell has gone out, it raises a one-cycle done pulse together with a
// completeness verdict.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   load         start request, sampled only while idle
//   puzzle_ans   packed grid, cell i at [i*WIDTH +: WIDTH], i = row*9+col
//   busy         high while sending and during the done cycle
//   cell_valid   cell_value/row/col/last are valid
//   cell_ready   consumer accepts the current cell
//   cell_value   value of the current cell
//   cell_row     row index 0..8
//   cell_col     column index 0..8
//   cell_last    high with cell (8,8) only
//   done         one-cycle pulse after the last transfer
//   empty_count  number of zero cells transferred so far
//   all_filled   high when the finished grid had no zero cells

module sudoku_cell_serializer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [81*WIDTH-1:0]  puzzle_ans,
  output logic                 busy,
  output logic                 cell_valid,
  input  logic                 cell_ready,
  output logic [WIDTH-1:0]     cell_value,
  output logic [3:0]           cell_row,
  output logic [3:0]           cell_col,
  output logic                 cell_last,
  output logic                 done,
  output logic [6:0]           empty_count,
  output logic                 all_filled
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_snap [81];
  logic [WIDTH-1:0] w_cells [81];
  logic [3:0]       r_row;
  logic [3:0]       r_col;
  logic [6:0]       r_idx;          // linear cell index, tracks row*9+col
  logic [6:0]       r_empty_count;
  logic             r_all_filled;

  logic [WIDTH-1:0] w_cell;
  logic             w_cell_zero;
  logic             w_at_last;
  logic             w_xfer;
  logic [6:0]       w_count_next;

  // Slice the packed grid into per-cell words for the snapshot capture.
  generate
    for (genvar gi = 0; gi < 81; gi++) begin : g_unpack
      assign w_cells[gi] = puzzle_ans[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_cell       = r_snap[r_idx];
  assign w_cell_zero  = ~|w_cell;
  assign w_at_last    = (r_row == 4'd8) && (r_col == 4'd8);
  assign w_xfer       = (r_state == S_SEND) && cell_ready;
  assign w_count_next = r_empty_count + {6'd0, w_cell_zero};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_next = S_SEND;
      S_SEND:  if (w_xfer && w_at_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= 4'd0;
      r_col         <= 4'd0;
      r_idx         <= 7'd0;
      r_empty_count <= 7'd0;
      r_all_filled  <= 1'b0;
      for (int i = 0; i < 81; i++) r_snap[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_snap        <= w_cells;
            r_row         <= 4'd0;
            r_col         <= 4'd0;
            r_idx         <= 7'd0;
            r_empty_count <= 7'd0;
            r_all_filled  <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_empty_count <= w_count_next;
            if (w_at_last) begin
              // Verdict lands together with the done pulse. It uses the count
              // that already includes the last cell.
              r_all_filled <= (w_count_next == 7'd0);
              r_row        <= 4'd0;
              r_col        <= 4'd0;
              r_idx        <= 7'd0;
            end else begin
              r_idx <= r_idx + 7'd1;
              if (r_col == 4'd8) begin
                r_col <= 4'd0;
                r_row <= r_row + 4'd1;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Cell outputs are gated by the SEND state so that they read zero when idle.
  assign busy        = (r_state != S_IDLE);
  assign cell_valid  = (r_state == S_SEND);
  assign cell_value  = cell_valid ? w_cell : '0;
  assign cell_row    = cell_valid ? r_row : 4'd0;
  assign cell_col    = cell_valid ? r_col : 4'd0;
  assign cell_last   = cell_valid && w_at_last;
  assign done        = (r_state == S_DONE);
  assign empty_count = r_empty_count;
  assign all_filled  = r_all_filled;

endmodule

// File: tb/tb_sudoku_cell_serializer.sv
module tb_sudoku_cell_serializer;

  logic          clk = 1'b0;
  logic          reset;

  // WIDTH=4 instance
  logic          load4, cell_ready4;
  logic [323:0]  puzzle_ans4;
  logic          busy4, cell_valid4, cell_last4, done4, all_filled4;
  logic [3:0]    cell_value4, cell_row4, cell_col4;
  logic [6:0]    empty_count4;

  // WIDTH=9 instance
  logic          load9, cell_ready9;
  logic [728:0]  puzzle_ans9;
  logic          busy9, cell_valid9, cell_last9, done9, all_filled9;
  logic [8:0]    cell_value9;
  logic [3:0]    cell_row9, cell_col9;
  logic [6:0]    empty_count9;

  logic [3:0]    grid4 [81];
  logic [8:0]    grid9 [81];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sudoku_cell_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load(load4), .puzzle_ans(puzzle_ans4),
    .busy(busy4), .cell_valid(cell_valid4), .cell_ready(cell_ready4),
    .cell_value(cell_value4), .cell_row(cell_row4), .cell_col(cell_col4),
    .cell_last(cell_last4), .done(done4), .empty_count(empty_count4),
    .all_filled(all_filled4)
  );

  sudoku_cell_serializer #(.WIDTH(9)) dut9 (
    .clk(clk), .reset(reset), .load(load9), .puzzle_ans(puzzle_ans9),
    .busy(busy9), .cell_valid(cell_valid9), .cell_ready(cell_ready9),
    .cell_value(cell_value9), .cell_row(cell_row9), .cell_col(cell_col9),
    .cell_last(cell_last9), .done(done9), .empty_count(empty_count9),
    .all_filled(all_filled9)
  );

  task automatic set_filled_grid4();
    for (int i = 0; i < 81; i++) grid4[i] = 4'((i % 9) + 1);
  endtask

  task automatic pack4();
    for (int i = 0; i < 81; i++) puzzle_ans4[i*4 +: 4] = grid4[i];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy4, cell_valid4, cell_value4, cell_row4, cell_col4, cell_last4, done4, empty_count4, all_filled4} !== 30'd0) begin
      fails++;
      $display("FAIL reset_outputs_w4: got busy=%b valid=%b val=%h row=%0d col=%0d last=%b done=%b empty=%0d filled=%b, want all 0",
               busy4, cell_valid4, cell_value4, cell_row4, cell_col4, cell_last4, done4, empty_count4, all_filled4);
    end
    checks++;
    if ({busy9, cell_valid9, cell_value9, cell_row9, cell_col9, cell_last9, done9, empty_count9, all_filled9} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs_w9: got busy=%b valid=%b val=%h empty=%0d, want all 0",
               busy9, cell_valid9, cell_value9, empty_count9);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy4 !== 1'b0 || cell_valid4 !== 1'b0 || done4 !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b valid=%b done=%b, want 0 0 0", busy4, cell_valid4, done4);
    end
    $display("test_reset complete");
  endtask

  // Streams grid4 through the WIDTH=4 instance, with load accepted at edge 0.
  // Cycle c is the interval that follows edge c. The model tracks the index of
  // the cell currently presented and the number of zero cells already accepted.
  task automatic run_stream4(input int ready_odd, input int load_cyc, input int reset_cyc,
                             input int exp_done, input int exp_empty, input string name);
    int idx, cnt, done_cyc;
    bit ended;
    idx = 0; cnt = 0; done_cyc = -1; ended = 1'b0;
    pack4();
    cell_ready4 = 1'b1;
    load4 = 1'b1;
    @(posedge clk);
    #1;
    load4 = 1'b0;
    for (int c = 1; c <= 200 && !ended; c++) begin
      cell_ready4 = (ready_odd != 0) ? ((c % 2) == 1) : 1'b1;
      if (c == load_cyc) begin
        load4 = 1'b1;
        puzzle_ans4 = ~puzzle_ans4;
      end else begin
        load4 = 1'b0;
      end
      if (c == reset_cyc) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({busy4, cell_valid4, cell_value4, cell_row4, cell_col4, cell_last4, done4, empty_count4, all_filled4} !== 30'd0) begin
          fails++;
          $display("FAIL %s midreset_outputs: busy=%b valid=%b val=%h row=%0d col=%0d empty=%0d, want all 0",
                   name, busy4, cell_valid4, cell_value4, cell_row4, cell_col4, empty_count4);
        end
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          checks++;
          if (done4 !== 1'b0 || busy4 !== 1'b0 || cell_valid4 !== 1'b0) begin
            fails++;
            $display("FAIL %s no_done_in_reset: done=%b busy=%b valid=%b, want 0 0 0", name, done4, busy4, cell_valid4);
          end
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        $display("%s: reset applied at cycle %0d", name, c);
        return;
      end
      if (idx < 81) begin
        checks++;
        if (cell_valid4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0 ||
            cell_value4 !== grid4[idx] || cell_row4 !== 4'(idx / 9) || cell_col4 !== 4'(idx % 9) ||
            cell_last4 !== (idx == 80) || empty_count4 !== 7'(cnt) || all_filled4 !== 1'b0) begin
          fails++;
          $display("FAIL %s cell%0d cyc%0d: got v=%b b=%b d=%b val=%h r=%0d c=%0d last=%b empty=%0d filled=%b, want 1 1 0 %h %0d %0d %b %0d 0",
                   name, idx, c, cell_valid4, busy4, done4, cell_value4, cell_row4, cell_col4, cell_last4,
                   empty_count4, all_filled4, grid4[idx], idx / 9, idx % 9, idx == 80, cnt);
        end
        if (cell_ready4) begin
          if (grid4[idx] == 4'd0) cnt++;
          idx++;
        end
      end else if (done_cyc < 0) begin
        done_cyc = c;
        checks++;
        if (done4 !== 1'b1 || cell_valid4 !== 1'b0 || busy4 !== 1'b1 || c != exp_done) begin
          fails++;
          $display("FAIL %s done_cycle: cyc=%0d done=%b valid=%b busy=%b, want cyc=%0d 1 0 1",
                   name, c, done4, cell_valid4, busy4, exp_done);
        end
        checks++;
        if (empty_count4 !== 7'(exp_empty) || all_filled4 !== (exp_empty == 0)) begin
          fails++;
          $display("FAIL %s verdict: empty=%0d filled=%b, want %0d %b",
                   name, empty_count4, all_filled4, exp_empty, exp_empty == 0);
        end
      end else begin
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || cell_valid4 !== 1'b0 ||
            empty_count4 !== 7'(exp_empty) || all_filled4 !== (exp_empty == 0)) begin
          fails++;
          $display("FAIL %s idle_hold: busy=%b done=%b valid=%b empty=%0d filled=%b, want 0 0 0 %0d %b",
                   name, busy4, done4, cell_valid4, empty_count4, all_filled4, exp_empty, exp_empty == 0);
        end
        ended = 1'b1;
      end
      if (!ended) begin
        @(posedge clk);
        #1;
      end
    end
    load4 = 1'b0;
    if (!ended) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: stream did not finish, cells seen=%0d, want 81", name, idx);
    end else begin
      $display("%s: stream finished, done at cycle %0d, empty=%0d", name, done_cyc, cnt);
    end
  endtask

  task automatic test_filled();
    set_filled_grid4();
    run_stream4(0, 0, 0, 82, 0, "filled");
  endtask

  task automatic test_zeros();
    set_filled_grid4();
    grid4[0] = 4'd0; grid4[40] = 4'd0; grid4[80] = 4'd0;
    run_stream4(0, 0, 0, 82, 3, "zeros");
  endtask

  task automatic test_backpressure();
    set_filled_grid4();
    grid4[13] = 4'd0;
    run_stream4(1, 0, 0, 162, 1, "backpressure");
  endtask

  task automatic test_load_ignored();
    set_filled_grid4();
    run_stream4(0, 30, 0, 82, 0, "load_ignored");
  endtask

  task automatic test_reset_midstream();
    set_filled_grid4();
    grid4[5] = 4'd0;
    run_stream4(0, 0, 50, 82, 0, "reset_mid");
    set_filled_grid4();
    grid4[80] = 4'd0;
    run_stream4(0, 0, 0, 82, 1, "after_reset");
  endtask

  task automatic test_width9();
    int idx, cnt;
    bit ended;
    for (int i = 0; i < 81; i++) grid9[i] = 9'd1 << (i % 9);
    grid9[17] = 9'd0;
    for (int i = 0; i < 81; i++) puzzle_ans9[i*9 +: 9] = grid9[i];
    idx = 0; cnt = 0; ended = 1'b0;
    cell_ready9 = 1'b1;
    load9 = 1'b1;
    @(posedge clk);
    #1;
    load9 = 1'b0;
    puzzle_ans9 = '1;   // changing the input after capture must not matter
    for (int c = 1; c <= 100 && !ended; c++) begin
      if (idx < 81) begin
        checks++;
        if (cell_valid9 !== 1'b1 || cell_value9 !== grid9[idx] || cell_row9 !== 4'(idx / 9) ||
            cell_col9 !== 4'(idx % 9) || cell_last9 !== (idx == 80) || empty_count9 !== 7'(cnt)) begin
          fails++;
          $display("FAIL w9 cell%0d: got v=%b val=%h r=%0d c=%0d last=%b empty=%0d, want 1 %h %0d %0d %b %0d",
                   idx, cell_valid9, cell_value9, cell_row9, cell_col9, cell_last9, empty_count9,
                   grid9[idx], idx / 9, idx % 9, idx == 80, cnt);
        end
        if (grid9[idx] == 9'd0) cnt++;
        idx++;
      end else begin
        checks++;
        if (done9 !== 1'b1 || c != 82 || empty_count9 !== 7'd1 || all_filled9 !== 1'b0) begin
          fails++;
          $display("FAIL w9 done: cyc=%0d done=%b empty=%0d filled=%b, want cyc=82 1 1 0",
                   c, done9, empty_count9, all_filled9);
        end
        ended = 1'b1;
      end
      if (!ended) begin
        @(posedge clk);
        #1;
      end
    end
    if (!ended) begin
      checks++;
      fails++;
      $display("FAIL w9 timeout: cells seen=%0d, want 81", idx);
    end else begin
      $display("width9: stream finished, empty=%0d", cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    load4 = 1'b0; cell_ready4 = 1'b0; puzzle_ans4 = '0;
    load9 = 1'b0; cell_ready9 = 1'b0; puzzle_ans9 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_filled();
    test_zeros();
    test_backpressure();
    test_load_ignored();
    test_reset_midstream();
    test_width9();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
